// File: rtl/cg_ctrl_pkg.sv
// Shared types and defaults for the clock-gate enable controller.
package cg_ctrl_pkg;

  // Controller state; encoding 3 is unused and treated as ACTIVE.
  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_GATED  = 2'd1,
    ST_WAKE   = 2'd2
  } cg_state_e;

  localparam int CG_IDLE_CYCLES_DEF = 16;
  localparam int CG_WAKE_CYCLES_DEF = 2;

  // Larger of two ints; sizes the shared idle/wake counter.
  function automatic int cg_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clock_gate_enable_ctrl.sv
// Idle-detect controller producing the registered enable for a latch-based
// clock gating cell. Gates after IDLE_CYCLES qualifying cycles, then runs the
// clock for WAKE_CYCLES on wake-up before resuming normal operation.
module clock_gate_enable_ctrl
  import cg_ctrl_pkg::*;
#(
  parameter int IDLE_CYCLES = CG_IDLE_CYCLES_DEF,
  parameter int WAKE_CYCLES = CG_WAKE_CYCLES_DEF,
  parameter int CNT_W       = $clog2(cg_max(IDLE_CYCLES, WAKE_CYCLES) + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cg_allow,
  input  logic             busy,
  input  logic             wake_req,
  output logic             gate_en,
  output logic             gated,
  output logic             wake_ack,
  output logic [CNT_W-1:0] idle_cnt
);

  if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1) begin : g_bad_param
    $error("clock_gate_enable_ctrl: IDLE_CYCLES and WAKE_CYCLES must be >= 1");
  end

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  cg_state_e        state_q, state_d;
  logic             gate_en_q, gate_en_d;
  logic             gated_q, gated_d;
  logic             wake_ack_q, wake_ack_d;
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             qual;

  // Cycle in which gating would be harmless: permitted, no work, no request.
  assign qual = cg_allow & ~busy & ~wake_req;

  // Next state, shared counter and registered outputs.
  always_comb begin
    state_d    = ST_ACTIVE;
    idle_cnt_d = '0;
    wake_ack_d = 1'b0;
    case (state_q)
      ST_GATED: begin
        state_d = (wake_req | busy | ~cg_allow) ? ST_WAKE : ST_GATED;
      end
      ST_WAKE: begin
        // Fixed-length run; inputs are deliberately ignored here.
        if (idle_cnt_q == WAKE_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          state_d    = ST_WAKE;
          idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // ACTIVE (and the unused encoding): any break in qual restarts the window.
        wake_ack_d = wake_req & ~wake_ack_q;
        if (qual) begin
          if (idle_cnt_q == IDLE_LAST) state_d = ST_GATED;
          else                         idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end
      end
    endcase
    // Outputs are decoded from the next state so they leave a flop directly.
    gate_en_d = (state_d != ST_GATED);
    gated_d   = (state_d == ST_GATED);
  end

  // State and output registers; reset keeps the gated clock running.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_ACTIVE;
      gate_en_q  <= 1'b1;
      gated_q    <= 1'b0;
      wake_ack_q <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gate_en_q  <= gate_en_d;
      gated_q    <= gated_d;
      wake_ack_q <= wake_ack_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign gate_en  = gate_en_q;
  assign gated    = gated_q;
  assign wake_ack = wake_ack_q;
  assign idle_cnt = idle_cnt_q;

endmodule

// File: tb/tb_clock_gate_enable_ctrl.sv
// Bench for clock_gate_enable_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2:
// directed vector table, latency sequences, then random traffic vs. a model.
module tb_clock_gate_enable_ctrl;

  localparam int IDLE = 4;
  localparam int WAKE = 2;

  logic       clk = 1'b0;
  logic       rst, cg_allow, busy, wake_req;
  logic       gate_en, gated, wake_ack;
  logic [2:0] idle_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  clock_gate_enable_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut (
    .clk(clk), .rst(rst), .cg_allow(cg_allow), .busy(busy), .wake_req(wake_req),
    .gate_en(gate_en), .gated(gated), .wake_ack(wake_ack), .idle_cnt(idle_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       r, a, b, w;
    logic       ge, gt, ack;
    logic [2:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Inputs change at negedge; outputs are sampled 1 time unit after posedge.
  task automatic drive(input logic r, input logic a, input logic b, input logic w);
    @(negedge clk);
    rst = r; cg_allow = a; busy = b; wake_req = w;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, a, b, w, ge, gt, ack, input int cnt);
    vec_t v;
    v.r = r; v.a = a; v.b = b; v.w = w;
    v.ge = ge; v.gt = gt; v.ack = ack; v.cnt = 3'(cnt);
    tbl.push_back(v);
  endtask

  // Behavioural reference: tracks idle run length, remaining wake cycles
  // and gated status directly from the rules.
  bit m_gated, m_ack;
  int m_run, m_wake_left;

  task automatic model_step(input logic r, a, b, w);
    bit nack;
    if (r) begin
      m_gated = 0; m_ack = 0; m_run = 0; m_wake_left = 0;
      return;
    end
    nack = !m_gated && m_wake_left == 0 && w && !m_ack;
    if (m_gated) begin
      if (w || b || !a) begin
        m_gated = 0;
        m_wake_left = WAKE;
      end
    end else if (m_wake_left > 0) begin
      m_wake_left--;
      m_run = 0;
    end else begin
      m_run = (a && !b && !w) ? m_run + 1 : 0;
      if (m_run == IDLE) begin
        m_gated = 1;
        m_run = 0;
      end
    end
    m_ack = nack;
  endtask

  function automatic int model_cnt();
    if (m_gated) return 0;
    if (m_wake_left > 0) return WAKE - m_wake_left;
    return m_run;
  endfunction

  initial begin
    int cyc;
    rst = 1'b1; cg_allow = 1'b0; busy = 1'b0; wake_req = 1'b0;

    //    r a b w   ge gt ack cnt
    add(1,1,0,0, 1,0,0,0);
    add(1,0,1,1, 1,0,0,0);
    add(1,1,0,0, 1,0,0,0);
    add(0,1,0,0, 1,0,0,1);
    add(0,1,0,0, 1,0,0,2);
    add(0,1,1,0, 1,0,0,0);   // busy breaks the idle window
    add(0,1,0,0, 1,0,0,1);
    add(0,1,0,0, 1,0,0,2);
    add(0,1,0,0, 1,0,0,3);
    add(0,0,0,0, 1,0,0,0);   // q drops at IDLE-1: no gating
    add(0,1,0,0, 1,0,0,1);
    add(0,1,0,0, 1,0,0,2);
    add(0,1,0,0, 1,0,0,3);
    add(0,1,0,0, 0,1,0,0);   // gated
    add(0,1,0,0, 0,1,0,0);
    add(0,1,0,1, 1,0,0,0);   // wake_req -> WAKE
    add(0,1,0,1, 1,0,0,1);
    add(0,1,0,1, 1,0,0,0);   // ACTIVE
    add(0,1,0,1, 1,0,1,0);   // ack
    add(0,1,0,0, 1,0,0,1);   // requester drops
    add(0,1,0,0, 1,0,0,2);
    add(0,1,0,0, 1,0,0,3);
    add(0,1,0,0, 0,1,0,0);   // re-gated
    add(0,0,0,0, 1,0,0,0);   // permission lost -> WAKE
    add(0,0,0,0, 1,0,0,1);
    add(0,0,0,0, 1,0,0,0);
    add(0,0,0,0, 1,0,0,0);   // no re-gating, no ack
    add(0,0,0,0, 1,0,0,0);
    add(0,1,0,0, 1,0,0,1);
    add(0,1,0,0, 1,0,0,2);
    add(0,1,0,0, 1,0,0,3);
    add(0,1,0,0, 0,1,0,0);
    add(0,1,1,0, 1,0,0,0);   // busy in GATED -> WAKE
    add(0,1,0,0, 1,0,0,1);   // WAKE ignores q
    add(0,1,0,0, 1,0,0,0);
    add(0,1,0,0, 1,0,0,1);
    add(0,1,0,0, 1,0,0,2);
    add(0,1,0,0, 1,0,0,3);
    add(0,1,0,0, 0,1,0,0);
    add(1,1,0,0, 1,0,0,0);   // reset mid-GATED
    add(0,1,0,1, 1,0,1,0);   // request while ACTIVE: ack next cycle
    add(0,1,0,0, 1,0,0,1);
    add(0,1,0,1, 1,0,1,0);   // held request: every other cycle
    add(0,1,0,1, 1,0,0,0);
    add(0,1,0,1, 1,0,1,0);
    add(0,1,0,0, 1,0,0,1);
    add(0,1,0,0, 1,0,0,2);
    add(0,1,0,0, 1,0,0,3);
    add(0,1,0,0, 0,1,0,0);
    add(0,1,0,1, 1,0,0,0);   // WAKE
    add(1,1,0,1, 1,0,0,0);   // reset mid-WAKE
    add(0,1,0,1, 1,0,1,0);

    foreach (tbl[i]) begin
      drive(tbl[i].r, tbl[i].a, tbl[i].b, tbl[i].w);
      chk($sformatf("vec%0d.gate_en", i),  32'(gate_en),  32'(tbl[i].ge));
      chk($sformatf("vec%0d.gated", i),    32'(gated),    32'(tbl[i].gt));
      chk($sformatf("vec%0d.wake_ack", i), 32'(wake_ack), 32'(tbl[i].ack));
      chk($sformatf("vec%0d.idle_cnt", i), 32'(idle_cnt), 32'(tbl[i].cnt));
    end

    // Gating latency: first qualifying cycle to gate_en low.
    drive(1,1,0,0);
    drive(0,1,0,0);
    cyc = 1;
    while (gate_en && cyc < 20) begin
      drive(0,1,0,0);
      cyc++;
    end
    chk("gate_latency", 32'(cyc), 32'(IDLE));

    // Wake latency: request raised in GATED to wake_ack.
    drive(0,1,0,1);
    cyc = 1;
    chk("wake_gate_en_next", 32'(gate_en), 32'd1);
    while (!wake_ack && cyc < 20) begin
      drive(0,1,0,1);
      cyc++;
    end
    chk("wake_ack_latency", 32'(cyc), 32'(WAKE + 2));
    drive(0,1,0,0);
    chk("wake_ack_single", 32'(wake_ack), 32'd0);

    // Random traffic against the reference model.
    drive(1,1,0,0);
    model_step(1,1,0,0);
    for (int k = 0; k < 3000; k++) begin
      logic r, a, b, w;
      r = ($urandom_range(99) == 0);
      a = ($urandom_range(9) != 0);
      b = ($urandom_range(7) == 0);
      w = ($urandom_range(11) == 0) || (wake_req && !wake_ack && $urandom_range(3) != 0);
      drive(r, a, b, w);
      model_step(r, a, b, w);
      chk("rnd.gate_en",  32'(gate_en),  32'(!m_gated));
      chk("rnd.gated",    32'(gated),    32'(m_gated));
      chk("rnd.wake_ack", 32'(wake_ack), 32'(m_ack));
      chk("rnd.idle_cnt", 32'(idle_cnt), 32'(model_cnt()));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_gate_enable_ctrl.md
# clock_gate_enable_ctrl

Idle-detect controller that generates the enable for the latch-based glitch-free clock gating cell. It runs on the free-running clock and watches activity and permission inputs. After a programmable run of idle cycles it drops the enable; on a wake request, activity, or loss of permission it restores the enable and handshakes the wake-up back to the requester. `gate_en` is the only signal the gating cell consumes and is driven straight from a flop.

## Interface

Parameters:
- `IDLE_CYCLES`, 16: consecutive qualifying idle cycles before gating; legal range ≥1.
- `WAKE_CYCLES`, 2: cycles the clock runs in WAKE before returning to ACTIVE; legal range ≥1.
- `CNT_W`, `$clog2(max(IDLE_CYCLES,WAKE_CYCLES)+1)`: width of the shared counter (derived).

Ports:
- `clk`  in  1  free-running clock; one clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `cg_allow`  in  1  gating permitted (software control), level.
- `busy`  in  1  pending work for the gated domain, level, free-clock domain.
- `wake_req`  in  1  wake request; level, held until `wake_ack` is seen.
- `gate_en`  out  1  enable to the clock gating cell; registered.
- `gated`  out  1  status: 1 while the clock is stopped; registered.
- `wake_ack`  out  1  single-cycle wake acknowledge; registered.
- `idle_cnt`  out  CNT_W  current counter value, for debug/observability.

## Operation

- Qualifying cycle: `q = cg_allow & ~busy & ~wake_req`.
- States: ACTIVE, GATED, WAKE. Reset state is ACTIVE.
- Reset values: `gate_en`=1, `gated`=0, `wake_ack`=0, `idle_cnt`=0.
- Reset is chosen with `gate_en`=1 so downstream logic sees clock edges during reset.
- ACTIVE (`gate_en`=1):
  - `q`=1: `idle_cnt` increments.
  - `q`=0: `idle_cnt` clears to 0.
  - `q`=1 with `idle_cnt`==IDLE_CYCLES-1: next state GATED and `idle_cnt` clears.
- GATED (`gate_en`=0, `gated`=1):
  - `idle_cnt` is held at 0.
  - `wake_req | busy | ~cg_allow`: next state WAKE.
- WAKE (`gate_en`=1, `gated`=0):
  - `idle_cnt` counts 0..WAKE_CYCLES-1.
  - At WAKE_CYCLES-1 the next state is ACTIVE and `idle_cnt` clears.
  - WAKE ignores all inputs; it cannot be aborted except by `rst`.
- `wake_ack` next value = (state==ACTIVE) & `wake_req` & ~`wake_ack`.
  - Result is a one-cycle pulse; a requester that drops `wake_req` the cycle after seeing ack gets exactly one pulse.
  - A held `wake_req` produces a pulse every other cycle; requesters must not hold it.
  - `wake_ack` is never asserted in GATED or WAKE.
- `wake_req` in ACTIVE, clock already running: ack follows one cycle later, no state change.
- Counting only in ACTIVE means any break in `q` restarts the idle window from 0.

## Timing

- All outputs are flop outputs; no combinational input-to-output path.
- `gate_en` changes only after a rising edge of `clk`, so the gating cell's low-phase-transparent latch samples a stable value.
- Gating latency: first qualifying cycle at t, `q` held high → `gate_en`=0 from cycle t+IDLE_CYCLES.
- Wake latency: request (`wake_req` rising) in GATED at cycle t:
  - WAKE with `gate_en`=1 at t+1.
  - ACTIVE at t+1+WAKE_CYCLES.
  - `wake_ack` at t+2+WAKE_CYCLES.
- `busy` or `~cg_allow` in GATED: same WAKE/ACTIVE timing, no ack.
- IDLE_CYCLES=1: gate one cycle after the first qualifying cycle.
- `q` dropping in the same cycle `idle_cnt` reaches IDLE_CYCLES-1: no gating, counter clears.
- Reset mid-GATED or mid-WAKE: ACTIVE with `gate_en`=1 on the cycle after `rst` is sampled.

## Structure

- `cg_ctrl_pkg`:
  - state typedef, 2-bit enum: ACTIVE=0, GATED=1, WAKE=2; value 3 is illegal and decodes to ACTIVE.
  - shared default constants for IDLE_CYCLES and WAKE_CYCLES.
- Single module, no sub-module. One shared counter serves both the idle and wake phases.
- Elaboration-time assertion rejects IDLE_CYCLES<1 or WAKE_CYCLES<1.

## Test plan

Bench parameters: IDLE_CYCLES=4, WAKE_CYCLES=2.

- Reset: `rst`=1 for 3 cycles with any inputs → `gate_en`=1, `gated`=0, `wake_ack`=0, `idle_cnt`=0 on the cycle after release.
- Idle gating: `cg_allow`=1, `busy`=0, `wake_req`=0 from cycle 10 → `idle_cnt` 1,2,3 on cycles 11–13; `gate_en`=0 and `gated`=1 at cycle 14.
- Interrupted idle: `busy` pulses high at cycle 12 of the previous scenario → `idle_cnt`=0 at 13; `gate_en` falls at 17 instead of 14.
- Wake handshake: `wake_req` rises at cycle 20 while GATED → `gate_en`=1 at 21, ACTIVE at 23, `wake_ack`=1 at 24 only; requester drops `wake_req` at 25; then `q` for 4 cycles re-gates.
- Permission/activity wake: `cg_allow` falls while GATED → WAKE next cycle, ACTIVE 2 cycles later, `wake_ack` stays 0, no re-gating while `cg_allow`=0.
- Reset mid-GATED: `rst`=1 one cycle while GATED → `gate_en`=1 the next cycle; `wake_ack` never pulses.
